// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// AxiMemSlave (module axi_mem_slave)
//
// AXI4 responder backed by an internal array of 32-bit words. It sits at the
// far end of a tile's memory initiator and holds match-table and action data
// in simulation and single-tile FPGA builds. Write and read channels are
// independent FSMs sharing one dual-port array, so a read and a write may
// proceed at the same time. FIXED and INCR bursts of up to 256 beats.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   axi_aw* / axi_awready        write address channel (id, addr, len, size, burst)
//   axi_w*  / axi_wready         write data channel (data, strobes, last)
//   axi_b*  / axi_bready         write response channel (id, resp)
//   axi_ar* / axi_arready        read address channel (id, addr, len, size, burst)
//   axi_r*  / axi_rready         read data channel (id, data, resp, last)
//
// Responses: OKAY for a good burst, DECERR when the start address misses the
// window [BASE_ADDR, BASE_ADDR + 4<<DEPTH_LOG2), SLVERR for any size other
// than 4 bytes or a write burst whose wlast does not land on beat awlen.
// Error bursts never touch the array and read back as zero.
// ---------------------------------------------------------------------------
module axi_mem_slave #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    // write address
    input  logic        axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    // write data
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    // write response
    output logic        axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    // read address
    input  logic        axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    // read data
    output logic        axi_rid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

    logic [31:0] mem [DEPTH];

    // ---------------- address decode ----------------
    // The window check is done on the full offset; an address below BASE_ADDR
    // wraps to a huge offset and so also falls outside the window.
    logic [31:0]           awOffset_d, arOffset_d;
    logic [1:0]            awResp_d, arResp_d;
    logic [DEPTH_LOG2-1:0] awIndex_d, arIndex_d;

    assign awOffset_d = axi_awaddr - BASE_ADDR;
    assign arOffset_d = axi_araddr - BASE_ADDR;
    assign awIndex_d  = awOffset_d[DEPTH_LOG2+1:2];
    assign arIndex_d  = arOffset_d[DEPTH_LOG2+1:2];

    // Decode error takes priority over an unsupported size.
    assign awResp_d = ({1'b0, awOffset_d} >= MEM_BYTES) ? RESP_DECERR :
                      (axi_awsize != 3'b010)            ? RESP_SLVERR : RESP_OKAY;
    assign arResp_d = ({1'b0, arOffset_d} >= MEM_BYTES) ? RESP_DECERR :
                      (axi_arsize != 3'b010)            ? RESP_SLVERR : RESP_OKAY;

    // ---------------- write channel ----------------
    wState_t               wState_q;
    logic                  wId_q;
    logic [DEPTH_LOG2-1:0] wIdx_q, wIdx_d;
    logic                  wFixed_q;
    logic [7:0]            wLen_q, wBeat_q;
    logic                  wOver_q;   // beat awlen already taken; later beats are dropped
    logic [1:0]            wErr_q;
    logic                  bId_q;
    logic [1:0]            bResp_q;
    logic                  wBeatFire_d, wWrite_d;

    assign wIdx_d      = wFixed_q ? wIdx_q : wIdx_q + IDX_ONE;
    assign wBeatFire_d = (wState_q == W_DATA) && axi_wvalid;
    assign wWrite_d    = wBeatFire_d && (wErr_q == RESP_OKAY) && !wOver_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState_q <= W_IDLE;
            wId_q    <= 1'b0;
            wIdx_q   <= '0;
            wFixed_q <= 1'b0;
            wLen_q   <= 8'd0;
            wBeat_q  <= 8'd0;
            wOver_q  <= 1'b0;
            wErr_q   <= RESP_OKAY;
            bId_q    <= 1'b0;
            bResp_q  <= RESP_OKAY;
        end else begin
            case (wState_q)
                W_IDLE: begin
                    if (axi_awvalid) begin
                        wId_q    <= axi_awid;
                        wIdx_q   <= awIndex_d;
                        wFixed_q <= (axi_awburst == 2'b00);
                        wLen_q   <= axi_awlen;
                        wBeat_q  <= 8'd0;
                        wOver_q  <= 1'b0;
                        wErr_q   <= awResp_d;
                        wState_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid) begin
                        if (!wOver_q) begin
                            wIdx_q <= wIdx_d;
                            if (wBeat_q == wLen_q) begin
                                wOver_q <= 1'b1;
                            end else begin
                                wBeat_q <= wBeat_q + 8'd1;
                            end
                        end
                        // Only wlast ends the burst; a mismatch against awlen
                        // is reported but already-written beats stay written.
                        if (axi_wlast) begin
                            bId_q <= wId_q;
                            if (wErr_q != RESP_OKAY) begin
                                bResp_q <= wErr_q;
                            end else if (wOver_q || (wBeat_q != wLen_q)) begin
                                bResp_q <= RESP_SLVERR;
                            end else begin
                                bResp_q <= RESP_OKAY;
                            end
                            wState_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        wState_q <= W_IDLE;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    // Array write port: no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wWrite_d) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) begin
                    mem[wIdx_q][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // The IDLE states are the reset states, so the ready flags are gated to
    // keep every output low while reset is held.
    assign axi_awready = !rst && (wState_q == W_IDLE);
    assign axi_wready  = (wState_q == W_DATA);
    assign axi_bvalid  = (wState_q == W_RESP);
    assign axi_bid     = bId_q;
    assign axi_bresp   = bResp_q;

    // ---------------- read channel ----------------
    rState_t               rState_q;
    logic                  rId_q;
    logic [DEPTH_LOG2-1:0] rIdx_q, rIdx_d;
    logic                  rFixed_q;
    logic [7:0]            rLen_q, rBeat_q;
    logic [1:0]            rResp_q;
    logic [31:0]           rData_q;
    logic                  rLast_q;

    assign rIdx_d = rFixed_q ? rIdx_q : rIdx_q + IDX_ONE;

    // R_FETCH reads the array one cycle before the beat is presented; a write
    // landing on the same word in that cycle is not yet visible, so the read
    // returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q <= R_IDLE;
            rId_q    <= 1'b0;
            rIdx_q   <= '0;
            rFixed_q <= 1'b0;
            rLen_q   <= 8'd0;
            rBeat_q  <= 8'd0;
            rResp_q  <= RESP_OKAY;
            rData_q  <= 32'h0;
            rLast_q  <= 1'b0;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    if (axi_arvalid) begin
                        rId_q    <= axi_arid;
                        rIdx_q   <= arIndex_d;
                        rFixed_q <= (axi_arburst == 2'b00);
                        rLen_q   <= axi_arlen;
                        rBeat_q  <= 8'd0;
                        rResp_q  <= arResp_d;
                        rState_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rData_q  <= (rResp_q == RESP_OKAY) ? mem[rIdx_q] : 32'h0;
                    rLast_q  <= (rBeat_q == rLen_q);
                    rState_q <= R_DATA;
                end
                R_DATA: begin
                    if (axi_rready) begin
                        if (rLast_q) begin
                            rState_q <= R_IDLE;
                        end else begin
                            rIdx_q   <= rIdx_d;
                            rBeat_q  <= rBeat_q + 8'd1;
                            rState_q <= R_FETCH;
                        end
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    assign axi_arready = !rst && (rState_q == R_IDLE);
    assign axi_rvalid  = (rState_q == R_DATA);
    assign axi_rid     = rId_q;
    assign axi_rdata   = rData_q;
    assign axi_rresp   = rResp_q;
    assign axi_rlast   = rLast_q;

endmodule
